// File: rtl/axis_width_combin_b1_if.sv
// Stream bundle for the narrow-to-wide combiner: narrow input side plus packed wide output side.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready are both high.
interface axis_width_combin_b1_if #(
    parameter int SLIM_DSIZE = 8,
    parameter int NSIZE      = 4
);
    localparam int KSIZE = SLIM_DSIZE / 8;
    localparam int W     = SLIM_DSIZE * NSIZE;
    localparam int CW    = $clog2(NSIZE + 1);

    logic [SLIM_DSIZE-1:0]  slim_tdata;
    logic [KSIZE-1:0]       slim_tkeep;
    logic                   slim_tvalid;
    logic                   slim_tlast;
    logic                   slim_tuser;
    logic                   slim_tready;

    logic [W-1:0]           wide_tdata;
    logic [KSIZE*NSIZE-1:0] wide_tkeep;
    logic                   wide_tvalid;
    logic                   wide_tlast;
    logic                   wide_tuser;
    logic [CW-1:0]          wide_tfill;
    logic                   wide_tready;

    // Environment side: produces narrow beats, consumes wide words.
    modport master (
        output slim_tdata, slim_tkeep, slim_tvalid, slim_tlast, slim_tuser,
        input  slim_tready,
        input  wide_tdata, wide_tkeep, wide_tvalid, wide_tlast, wide_tuser, wide_tfill,
        output wide_tready
    );

    modport slave (
        input  slim_tdata, slim_tkeep, slim_tvalid, slim_tlast, slim_tuser,
        output slim_tready,
        output wide_tdata, wide_tkeep, wide_tvalid, wide_tlast, wide_tuser, wide_tfill,
        input  wide_tready
    );
endinterface

// File: rtl/axis_width_combin_b1.sv
// AXI-Stream upsizer: packs NSIZE narrow beats into one wide word, with short-packet tails,
// sticky tuser and a lane fill count, at one narrow beat per cycle through a single output register.
module axis_width_combin_b1 #(
    parameter int SLIM_DSIZE = 8,
    parameter int NSIZE      = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    axis_width_combin_b1_if.slave      axis,
    output logic [$clog2(NSIZE)-1:0]   dbg_point
);
    localparam int KSIZE = SLIM_DSIZE / 8;
    localparam int W     = SLIM_DSIZE * NSIZE;
    localparam int CW    = $clog2(NSIZE + 1);
    localparam int PW    = $clog2(NSIZE);
    localparam logic [PW-1:0] LAST_POINT = PW'(NSIZE - 1);

    generate
        if ((SLIM_DSIZE % 8) != 0 || NSIZE < 2) begin : g_bad_params
            $error("axis_width_combin_b1: SLIM_DSIZE must be a multiple of 8 and NSIZE >= 2");
        end
    endgenerate

    logic [PW-1:0]          point;
    logic [PW-1:0]          lane;
    logic [W-1:0]           acc_data;
    logic [W-1:0]           nxt_data;
    logic [KSIZE*NSIZE-1:0] acc_keep;
    logic [KSIZE*NSIZE-1:0] nxt_keep;
    logic                   acc_user;
    logic                   slim_fire;
    logic                   wide_fire;
    logic                   complete;

    // The only stall source is a held, unaccepted output word.
    assign axis.slim_tready = ~axis.wide_tvalid | axis.wide_tready;
    assign slim_fire        = axis.slim_tvalid & axis.slim_tready;
    assign wide_fire        = axis.wide_tvalid & axis.wide_tready;
    assign complete         = (point == LAST_POINT) | axis.slim_tlast;
    assign lane             = MSB_FIRST ? (LAST_POINT - point) : point;
    assign dbg_point        = point;

    // Unwritten lanes are already zero because the accumulator clears on every completion.
    always_comb begin
        nxt_data = acc_data;
        nxt_keep = acc_keep;
        for (int i = 0; i < NSIZE; i++) begin
            if (lane == PW'(i)) begin
                nxt_data[i*SLIM_DSIZE +: SLIM_DSIZE] = axis.slim_tdata;
                nxt_keep[i*KSIZE +: KSIZE]           = axis.slim_tkeep;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            point            <= '0;
            acc_data         <= '0;
            acc_keep         <= '0;
            acc_user         <= 1'b0;
            axis.wide_tvalid <= 1'b0;
            axis.wide_tdata  <= '0;
            axis.wide_tkeep  <= '0;
            axis.wide_tlast  <= 1'b0;
            axis.wide_tuser  <= 1'b0;
            axis.wide_tfill  <= '0;
        end else begin
            if (slim_fire) begin
                if (complete) begin
                    axis.wide_tdata <= nxt_data;
                    axis.wide_tkeep <= nxt_keep;
                    axis.wide_tlast <= axis.slim_tlast;
                    axis.wide_tuser <= acc_user | axis.slim_tuser;
                    axis.wide_tfill <= CW'(point) + CW'(1);
                    point           <= '0;
                    acc_data        <= '0;
                    acc_keep        <= '0;
                    acc_user        <= 1'b0;
                end else begin
                    acc_data <= nxt_data;
                    acc_keep <= nxt_keep;
                    acc_user <= acc_user | axis.slim_tuser;
                    point    <= point + PW'(1);
                end
            end

            // A completion on the same edge as a wide transfer keeps valid high: no bubble.
            if (slim_fire && complete) begin
                axis.wide_tvalid <= 1'b1;
            end else if (wide_fire) begin
                axis.wide_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_width_combin_b1.sv
// Bench for axis_width_combin_b1: three configurations fed the same beat list with independent handshakes,
// checked against a packing model and a per-instance scoreboard.
module tb_axis_width_combin_b1;
  localparam int ND = 3;
  localparam int XW = 41;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       l;
    logic       u;
  } beat_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  axis_width_combin_b1_if #(.SLIM_DSIZE(8), .NSIZE(4)) if0 ();
  axis_width_combin_b1_if #(.SLIM_DSIZE(8), .NSIZE(4)) if1 ();
  axis_width_combin_b1_if #(.SLIM_DSIZE(8), .NSIZE(3)) if2 ();
  logic [1:0] dbg0, dbg1, dbg2;

  axis_width_combin_b1 #(.SLIM_DSIZE(8), .NSIZE(4), .MSB_FIRST(1'b1)) u0 (
    .aclk(clk), .aresetn(aresetn), .axis(if0.slave), .dbg_point(dbg0));
  axis_width_combin_b1 #(.SLIM_DSIZE(8), .NSIZE(4), .MSB_FIRST(1'b0)) u1 (
    .aclk(clk), .aresetn(aresetn), .axis(if1.slave), .dbg_point(dbg1));
  axis_width_combin_b1 #(.SLIM_DSIZE(8), .NSIZE(3), .MSB_FIRST(1'b1)) u2 (
    .aclk(clk), .aresetn(aresetn), .axis(if2.slave), .dbg_point(dbg2));

  logic       sv [ND];
  logic [7:0] sd [ND];
  logic       sk [ND];
  logic       sl [ND];
  logic       su [ND];
  logic       wr [ND];
  logic       sr [ND];
  logic       wv [ND];
  logic       wl [ND];
  logic       wu [ND];
  logic [31:0] wd [ND];
  logic [3:0]  wk [ND];
  logic [2:0]  wf [ND];

  assign if0.slim_tvalid = sv[0]; assign if0.slim_tdata = sd[0]; assign if0.slim_tkeep = sk[0];
  assign if0.slim_tlast = sl[0];  assign if0.slim_tuser = su[0]; assign if0.wide_tready = wr[0];
  assign if1.slim_tvalid = sv[1]; assign if1.slim_tdata = sd[1]; assign if1.slim_tkeep = sk[1];
  assign if1.slim_tlast = sl[1];  assign if1.slim_tuser = su[1]; assign if1.wide_tready = wr[1];
  assign if2.slim_tvalid = sv[2]; assign if2.slim_tdata = sd[2]; assign if2.slim_tkeep = sk[2];
  assign if2.slim_tlast = sl[2];  assign if2.slim_tuser = su[2]; assign if2.wide_tready = wr[2];

  assign sr[0] = if0.slim_tready; assign wv[0] = if0.wide_tvalid; assign wl[0] = if0.wide_tlast;
  assign wu[0] = if0.wide_tuser;  assign wd[0] = if0.wide_tdata;  assign wk[0] = if0.wide_tkeep;
  assign wf[0] = if0.wide_tfill;
  assign sr[1] = if1.slim_tready; assign wv[1] = if1.wide_tvalid; assign wl[1] = if1.wide_tlast;
  assign wu[1] = if1.wide_tuser;  assign wd[1] = if1.wide_tdata;  assign wk[1] = if1.wide_tkeep;
  assign wf[1] = if1.wide_tfill;
  assign sr[2] = if2.slim_tready; assign wv[2] = if2.wide_tvalid; assign wl[2] = if2.wide_tlast;
  assign wu[2] = if2.wide_tuser;  assign wd[2] = {8'h00, if2.wide_tdata};
  assign wk[2] = {1'b0, if2.wide_tkeep}; assign wf[2] = {1'b0, if2.wide_tfill};

  // stimulus state
  beat_t beats[$];
  int    idx [ND];
  bit    full_rate = 1'b1;
  int    bp_cnt = 0;
  bit    rst_req = 1'b1;
  bit    busy;

  // scoreboard / model state
  logic [XW-1:0] exp_q [ND][$];
  beat_t         part_q [ND][$];
  bit            pend [ND];
  bit            hold [ND];
  logic [XW-1:0] hold_word [ND];
  int            npop [ND];
  logic [31:0]   first_d [ND];
  bit            rst_prev = 1'b0;
  int            checks = 0;
  int            failures = 0;

  function automatic int nsize_of(int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic bit msb_of(int k);
    return k != 1;
  endfunction

  function automatic logic [XW-1:0] pack(logic [31:0] d, logic [3:0] kp, logic l, logic u, logic [2:0] f);
    return {d, kp, l, u, f};
  endfunction

  task automatic chk(string name, int k, logic [XW-1:0] act, logic [XW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- clock/reset + driver ----------------
  task automatic cycle();
    bit fired [ND];
    @(negedge clk);
    aresetn = !rst_req;
    for (int k = 0; k < ND; k++) begin
      if (aresetn && idx[k] < beats.size()) begin
        sv[k] = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
        sd[k] = beats[idx[k]].d;
        sk[k] = beats[idx[k]].k;
        sl[k] = beats[idx[k]].l;
        su[k] = beats[idx[k]].u;
      end else begin
        sv[k] = 1'b0;
        sd[k] = 8'h00;
        sk[k] = 1'b0;
        sl[k] = 1'b0;
        su[k] = 1'b0;
      end
      wr[k] = (bp_cnt > 0) ? 1'b0 : (full_rate ? 1'b1 : ($urandom_range(0, 2) != 0));
    end
    #4;
    busy = 1'b0;
    for (int k = 0; k < ND; k++) begin
      fired[k] = sv[k] && sr[k] && aresetn;
      if (idx[k] < beats.size() || wv[k]) busy = 1'b1;
    end
    @(posedge clk);
    for (int k = 0; k < ND; k++) if (fired[k]) idx[k]++;
    if (bp_cnt > 0) bp_cnt--;
  endtask

  task automatic push_beat(logic [7:0] d, logic kp, logic l, logic u);
    beat_t b;
    b.d = d; b.k = kp; b.l = l; b.u = u;
    beats.push_back(b);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (busy && n < 3000);
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=busy required=idle after %0d cycles", n);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_dut(int k);
    logic [XW-1:0] act;
    logic [XW-1:0] exp;
    logic [31:0]   d;
    logic [3:0]    kp;
    logic          u;
    int            n;
    int            lane;
    beat_t         b;
    act = pack(wd[k], wk[k], wl[k], wu[k], wf[k]);
    if (rst_prev) chk("reset_outputs", k, {act[XW-1:1], wv[k]}, '0);
    if (!aresetn) begin
      part_q[k].delete();
      exp_q[k].delete();
      pend[k] = 1'b0;
      hold[k] = 1'b0;
      return;
    end
    if (pend[k]) begin
      chk("valid_latency", k, XW'(wv[k]), XW'(1));
      pend[k] = 1'b0;
    end
    if (hold[k]) chk("hold_stable", k, {act[XW-1:1], wv[k]}, {hold_word[k][XW-1:1], 1'b1});
    if (wv[k] && !wr[k]) chk("slim_tready_stall", k, XW'(sr[k]), XW'(0));
    else                 chk("slim_tready_free", k, XW'(sr[k]), XW'(1));
    if (wv[k] && wr[k]) begin
      if (exp_q[k].size() == 0) begin
        chk("unexpected_word", k, act, '0);
      end else begin
        exp = exp_q[k].pop_front();
        chk("wide_word", k, act, exp);
        if (npop[k] == 0) first_d[k] = wd[k];
        npop[k]++;
      end
    end
    hold[k] = wv[k] && !wr[k];
    hold_word[k] = act;
    if (sv[k] && sr[k]) begin
      b.d = sd[k]; b.k = sk[k]; b.l = sl[k]; b.u = su[k];
      part_q[k].push_back(b);
      if (part_q[k].size() == nsize_of(k) || b.l) begin
        d = '0; kp = '0; u = 1'b0;
        n = part_q[k].size();
        for (int i = 0; i < n; i++) begin
          lane = msb_of(k) ? (nsize_of(k) - 1 - i) : i;
          d[lane*8 +: 8] = part_q[k][i].d;
          kp[lane] = part_q[k][i].k;
          u = u | part_q[k][i].u;
        end
        exp_q[k].push_back(pack(d, kp, b.l, u, 3'(n)));
        part_q[k].delete();
        pend[k] = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      for (int k = 0; k < ND; k++) mon_dut(k);
      rst_prev = !aresetn;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < ND; k++) begin
      idx[k] = 0; npop[k] = 0; first_d[k] = '0; pend[k] = 0; hold[k] = 0;
      sv[k] = 0; sd[k] = 0; sk[k] = 0; sl[k] = 0; su[k] = 0; wr[k] = 1;
    end
    rst_req = 1'b1;
    repeat (3) cycle();
    rst_req = 1'b0;

    // 4-beat packet
    push_beat(8'h11, 1, 0, 0); push_beat(8'h22, 1, 0, 0);
    push_beat(8'h33, 1, 0, 0); push_beat(8'h44, 1, 1, 0);
    drain();

    // 6-beat packet with short tail
    for (int i = 1; i <= 6; i++) push_beat(8'(i), 1, i == 6, 0);
    drain();

    // continuous stream
    for (int i = 0; i < 16; i++) push_beat(8'(8'h80 + i), 1, i == 15, 0);
    drain();

    // tuser only on the second beat of the first word
    for (int i = 0; i < 8; i++) push_beat(8'(8'hA0 + i), 1, i == 7, i == 1);
    drain();

    // backpressure while a word is valid
    bp_cnt = 5;
    for (int i = 0; i < 8; i++) push_beat(8'(8'hC0 + i), 1, i == 7, 0);
    drain();

    // reset after two beats discards the partial word
    push_beat(8'hE1, 1, 0, 1); push_beat(8'hE2, 1, 0, 0);
    drain();
    rst_req = 1'b1;
    repeat (2) cycle();
    rst_req = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(8'(8'hF0 + i), 1, i == 3, 0);
    drain();

    // randomized traffic
    full_rate = 1'b0;
    for (int i = 0; i < 300; i++)
      push_beat(8'($urandom), 1'($urandom_range(0, 1)), (i == 299) || ($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 7) == 0));
    drain();
    repeat (2) cycle();

    for (int k = 0; k < ND; k++) begin
      chk("exp_q_empty", k, XW'(exp_q[k].size()), XW'(0));
      chk("partial_empty", k, XW'(part_q[k].size()), XW'(0));
    end
    chk("first_word_msb", 0, XW'(first_d[0]), XW'(32'h11223344));
    chk("first_word_lsb", 1, XW'(first_d[1]), XW'(32'h44332211));
    chk("first_word_n3", 2, XW'(first_d[2]), XW'(32'h00112233));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
